ps2_device_model: RTL and testbench

- PS/2 device-side (mouse) endpoint: the far end of the host PS/2 interface used by the mouse subsystem.
- Generates the PS/2 clock, transmits device-to-host frames and receives host-to-device commands with line ack.
- Implements the mouse command subset: reset, enable streaming, plus generic ACK for other commands.
- Used as a bench/loopback partner for the mouse host logic and as an on-board emulator driven from switches.

---
 rtl/ps2_device_model.sv | 261 ++++++++++++++++++++++++++
 tb/tb_ps2_device_model.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device_model.sv
// PS/2 device-side (mouse) endpoint: drives the PS/2 clock, sends queued bytes and answers host commands.
// Optional macro PS2_DEV_PARITY_CHECK_EN: host bytes with bad parity are answered with 0xFE.
module ps2_device_model #(
  parameter int CLK_HALF   = 4000,
  parameter int RTS_MIN    = 10000,
  parameter int GAP_CYCLES = 8000
) (
  input  logic       CLK,
  input  logic       RESETN,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DATA,
  input  logic [7:0] PKT_STATUS,
  input  logic [7:0] PKT_DX,
  input  logic [7:0] PKT_DY,
  input  logic       PKT_VALID,
  output logic       PKT_READY,
  output logic       STREAM_EN,
  output logic [7:0] LAST_CMD,
  output logic       CMD_STROBE
);

  localparam int CW         = $clog2(RTS_MIN + 2 * CLK_HALF + GAP_CYCLES + 1);
  localparam int SYNC_GUARD = 3;
`ifdef PS2_DEV_PARITY_CHECK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, TX_LOW, TX_HIGH, GAP, RTS_WAIT, RX_LOW, RX_HIGH, RX_ACK
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [3:0]      bit_idx, bit_nxt;
  logic            clk_low, clk_low_nxt;
  logic            dat_low, dat_low_nxt;
  logic            clk_s1, clk_s, dat_s1, dat_s;
  logic [8:0]      rx_sh, rx_nxt;
  logic [7:0]      q [4];
  logic [1:0]      head;
  logic [2:0]      q_cnt;
  logic            init_pend;
  logic            pop, rx_done, cmd_ok, par_ok;
  logic            ld_en, stream_nxt;
  logic [1:0]      ld_n;
  logic [7:0]      ld_b0, ld_b1, ld_b2;
  logic [10:0]     tx_frame;

  assign PS2_CLK   = clk_low ? 1'b0 : 1'bz;
  assign PS2_DATA  = dat_low ? 1'b0 : 1'bz;
  assign tx_frame  = {1'b1, ~^q[head], q[head], 1'b0};
  assign par_ok    = ^rx_sh;
  assign cmd_ok    = rx_done && (!PAR_CHK || par_ok);
  assign PKT_READY = STREAM_EN && (q_cnt == 3'd0) && (state == IDLE);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      clk_s1  <= 1'b1;
      clk_s   <= 1'b1;
      dat_s1  <= 1'b1;
      dat_s   <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      clk_low <= 1'b0;
      dat_low <= 1'b0;
    end else begin
      clk_s1  <= PS2_CLK;
      clk_s   <= clk_s1;
      dat_s1  <= PS2_DATA;
      dat_s   <= dat_s1;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      clk_low <= clk_low_nxt;
      dat_low <= dat_low_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    rx_sh <= rx_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    bit_nxt     = bit_idx;
    clk_low_nxt = clk_low;
    dat_low_nxt = dat_low;
    rx_nxt      = rx_sh;
    pop         = 1'b0;
    rx_done     = 1'b0;
    case (state)
      IDLE: begin
        clk_low_nxt = 1'b0;
        dat_low_nxt = 1'b0;
        bit_nxt     = '0;
        if (clk_s) cnt_nxt = '0;
        if (!clk_s && cnt == CW'(RTS_MIN - 1)) begin
          state_nxt = RTS_WAIT;
          cnt_nxt   = '0;
        end else if (clk_s && q_cnt != 3'd0) begin
          state_nxt   = TX_HIGH;
          dat_low_nxt = 1'b1;
        end
      end
      // Our own clock release needs a few cycles to reach clk_s, so early samples are ignored.
      TX_HIGH: begin
        if (cnt >= CW'(SYNC_GUARD) && !clk_s && bit_idx < 4'd10) begin
          state_nxt   = IDLE;
          dat_low_nxt = 1'b0;
          cnt_nxt     = '0;
        end else if (cnt == CW'(CLK_HALF - 1)) begin
          state_nxt   = TX_LOW;
          clk_low_nxt = 1'b1;
          cnt_nxt     = '0;
        end
      end
      TX_LOW: begin
        if (cnt == CW'(CLK_HALF - 1)) begin
          clk_low_nxt = 1'b0;
          cnt_nxt     = '0;
          if (bit_idx == 4'd10) begin
            state_nxt   = GAP;
            dat_low_nxt = 1'b0;
            pop         = 1'b1;
          end else begin
            state_nxt   = TX_HIGH;
            bit_nxt     = bit_idx + 4'd1;
            dat_low_nxt = ~tx_frame[bit_idx + 4'd1];
          end
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      RTS_WAIT: begin
        cnt_nxt = '0;
        bit_nxt = '0;
        if (clk_s && !dat_s) begin
          state_nxt   = RX_LOW;
          clk_low_nxt = 1'b1;
        end else if (clk_s && dat_s) begin
          state_nxt = IDLE;
        end
      end
      RX_LOW: begin
        if (cnt == CW'(CLK_HALF - 1)) begin
          state_nxt   = RX_HIGH;
          clk_low_nxt = 1'b0;
          cnt_nxt     = '0;
        end
      end
      RX_HIGH: begin
        if (cnt == CW'(CLK_HALF - 1)) begin
          cnt_nxt = '0;
          if (bit_idx == 4'd9) begin
            if (dat_s) begin
              state_nxt   = RX_ACK;
              clk_low_nxt = 1'b1;
              dat_low_nxt = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            rx_nxt      = {dat_s, rx_sh[8:1]};
            bit_nxt     = bit_idx + 4'd1;
            state_nxt   = RX_LOW;
            clk_low_nxt = 1'b1;
          end
        end
      end
      RX_ACK: begin
        if (cnt == CW'(CLK_HALF - 1)) clk_low_nxt = 1'b0;
        if (cnt == CW'(2 * CLK_HALF - 1)) begin
          state_nxt   = IDLE;
          dat_low_nxt = 1'b0;
          cnt_nxt     = '0;
          rx_done     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Every enqueue replaces the whole queue: responses flush pending packet bytes.
  always_comb begin
    ld_en      = 1'b0;
    ld_n       = 2'd0;
    ld_b0      = 8'hFA;
    ld_b1      = 8'hAA;
    ld_b2      = 8'h00;
    stream_nxt = STREAM_EN;
    if (rx_done) begin
      ld_en = 1'b1;
      ld_n  = 2'd1;
      if (!cmd_ok) begin
        ld_b0 = 8'hFE;
      end else begin
        case (rx_sh[7:0])
          8'hFF: begin
            ld_n       = 2'd3;
            stream_nxt = 1'b0;
          end
          8'hF4:   stream_nxt = 1'b1;
          8'hF5:   stream_nxt = 1'b0;
          default: ;
        endcase
      end
    end else if (init_pend) begin
      ld_en = 1'b1;
      ld_n  = 2'd2;
      ld_b0 = 8'hAA;
      ld_b1 = 8'h00;
    end else if (PKT_VALID && PKT_READY) begin
      ld_en = 1'b1;
      ld_n  = 2'd3;
      ld_b0 = PKT_STATUS;
      ld_b1 = PKT_DX;
      ld_b2 = PKT_DY;
    end
  end

  always_ff @(posedge CLK) begin
    if (ld_en) begin
      q[0] <= ld_b0;
      q[1] <= ld_b1;
      q[2] <= ld_b2;
      q[3] <= 8'h00;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      head       <= '0;
      q_cnt      <= '0;
      init_pend  <= 1'b1;
      STREAM_EN  <= 1'b0;
      LAST_CMD   <= 8'h00;
      CMD_STROBE <= 1'b0;
    end else begin
      init_pend  <= 1'b0;
      CMD_STROBE <= cmd_ok;
      STREAM_EN  <= stream_nxt;
      if (cmd_ok) LAST_CMD <= rx_sh[7:0];
      if (ld_en) begin
        head  <= '0;
        q_cnt <= {1'b0, ld_n};
      end else if (pop) begin
        head  <= head + 2'd1;
        q_cnt <= q_cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_device_model.sv
// Bench for ps2_device_model: host-side stimulus with a line monitor feeding a byte scoreboard.
module tb_ps2_device_model;

  localparam int CLK_HALF   = 8;
  localparam int RTS_MIN    = 40;
  localparam int GAP_CYCLES = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  wire        ps2_clk;
  wire        ps2_data;
  logic       host_clk_low = 1'b0;
  logic       host_dat_low = 1'b0;
  logic       host_active = 1'b0;
  logic [7:0] pkt_status = 8'h00;
  logic [7:0] pkt_dx = 8'h00;
  logic [7:0] pkt_dy = 8'h00;
  logic       pkt_valid = 1'b0;
  logic       pkt_ready;
  logic       stream_en;
  logic [7:0] last_cmd;
  logic       cmd_strobe;

  int         n_checks = 0;
  int         n_fail = 0;
  int         frames_done = 0;
  int         strobe_cnt = 0;
  logic [7:0] exp_q[$];

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk  = host_clk_low ? 1'b0 : 1'bz;
  assign ps2_data = host_dat_low ? 1'b0 : 1'bz;

  ps2_device_model #(
    .CLK_HALF(CLK_HALF),
    .RTS_MIN(RTS_MIN),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .CLK(clk),
    .RESETN(rst_n),
    .PS2_CLK(ps2_clk),
    .PS2_DATA(ps2_data),
    .PKT_STATUS(pkt_status),
    .PKT_DX(pkt_dx),
    .PKT_DY(pkt_dy),
    .PKT_VALID(pkt_valid),
    .PKT_READY(pkt_ready),
    .STREAM_EN(stream_en),
    .LAST_CMD(last_cmd),
    .CMD_STROBE(cmd_strobe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && cmd_strobe) strobe_cnt = strobe_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line monitor: decodes device frames on falling clock edges and scores them.
  initial begin : monitor
    logic [10:0] fr;
    logic [7:0]  exp_b;
    logic        prev;
    int          nb;
    int          since;
    nb = 0;
    since = 0;
    prev = 1'b1;
    fr = '0;
    forever begin
      @(negedge clk);
      since++;
      if (host_active || !rst_n) begin
        nb = 0;
      end else if (prev && !ps2_clk) begin
        if (nb > 0) check("bit_period", 32'(since), 32'(2 * CLK_HALF));
        fr[nb] = ps2_data;
        nb++;
        since = 0;
        if (nb == 11) begin
          check("start_bit", 32'(fr[0]), 32'd0);
          check("stop_bit", 32'(fr[10]), 32'd1);
          check("odd_parity", 32'(^fr[9:1]), 32'd1);
          check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            check("tx_byte", 32'(fr[8:1]), 32'(exp_b));
          end
          frames_done++;
          nb = 0;
        end
      end else if (since > 4 * CLK_HALF) begin
        nb = 0;
      end
      prev = ps2_clk;
    end
  end

  task automatic wait_fall(input int lim, output bit ok);
    logic prev;
    prev = ps2_clk;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (prev && !ps2_clk) begin
        ok = 1'b1;
        break;
      end
      prev = ps2_clk;
    end
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("frames_reached", 32'(frames_done), 32'(target));
  endtask

  task automatic wait_ready(input logic want);
    int n;
    n = 0;
    while (pkt_ready !== want && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("pkt_ready_wait", 32'(pkt_ready), 32'(want));
  endtask

  task automatic host_send(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           output bit acked);
    logic [9:0] bits;
    bit         ok;
    bits = {~bad_stop, (~^b) ^ bad_par, b};
    host_active = 1'b1;
    host_clk_low = 1'b1;
    repeat (RTS_MIN + GAP_CYCLES + 10) @(negedge clk);
    host_dat_low = 1'b1;
    repeat (4) @(negedge clk);
    host_clk_low = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_fall(8 * CLK_HALF, ok);
      if (!ok) begin
        check("host_rx_clock", 32'(ok), 32'd1);
        break;
      end
      host_dat_low = ~bits[i];
    end
    wait_fall(4 * CLK_HALF, ok);
    acked = ok && (ps2_data === 1'b0);
    host_dat_low = 1'b0;
    if (ok) repeat (CLK_HALF + 4) @(negedge clk);
    else repeat (4) @(negedge clk);
    host_active = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    pkt_status = s;
    pkt_dx = x;
    pkt_dy = y;
    pkt_valid = 1'b1;
    @(negedge clk);
    pkt_valid = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit ack;
    int f0;

    repeat (3) @(negedge clk);
    check("rst_stream_en", 32'(stream_en), 32'd0);
    check("rst_pkt_ready", 32'(pkt_ready), 32'd0);
    check("rst_last_cmd", 32'(last_cmd), 32'h00);
    check("rst_cmd_strobe", 32'(cmd_strobe), 32'd0);
    check("rst_clk_released", 32'(ps2_clk), 32'd1);
    check("rst_data_released", 32'(ps2_data), 32'd1);

    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h00);
    rst_n = 1'b1;
    wait_frames(2);

    host_send(8'hF4, 1'b0, 1'b1, ack);
    check("badstop_no_ack", 32'(ack), 32'd0);
    repeat (20) @(negedge clk);
    check("badstop_last_cmd", 32'(last_cmd), 32'h00);
    check("badstop_strobes", 32'(strobe_cnt), 32'd0);
    check("badstop_no_reply", 32'(frames_done), 32'd2);

    exp_q.push_back(8'hFA);
    host_send(8'hF4, 1'b0, 1'b0, ack);
    check("f4_ack", 32'(ack), 32'd1);
    wait_frames(3);
    check("f4_stream_en", 32'(stream_en), 32'd1);
    check("f4_last_cmd", 32'(last_cmd), 32'hF4);
    check("f4_strobes", 32'(strobe_cnt), 32'd1);

    wait_ready(1'b1);
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h05);
    exp_q.push_back(8'hFB);
    send_pkt(8'h08, 8'h05, 8'hFB);
    check("pkt_ready_busy", 32'(pkt_ready), 32'd0);
    f0 = frames_done;
    wait_frames(f0 + 1);
    for (int i = 0; i < 4; i++) begin
      bit ok;
      wait_fall(8 * CLK_HALF, ok);
      if (!ok) check("abort_bit_edge", 32'(ok), 32'd1);
    end
    repeat (CLK_HALF + 2) @(negedge clk);
    host_active = 1'b1;
    host_clk_low = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_data_released", 32'(ps2_data), 32'd1);
    repeat (14) @(negedge clk);
    host_clk_low = 1'b0;
    repeat (2) @(negedge clk);
    host_active = 1'b0;
    wait_frames(f0 + 3);
    wait_ready(1'b1);

    exp_q.push_back(8'hFA);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h00);
    host_send(8'hFF, 1'b0, 1'b0, ack);
    check("ff_ack", 32'(ack), 32'd1);
    wait_frames(f0 + 6);
    check("ff_stream_en", 32'(stream_en), 32'd0);
    check("ff_last_cmd", 32'(last_cmd), 32'hFF);
    check("ff_strobes", 32'(strobe_cnt), 32'd2);
    repeat (GAP_CYCLES + 20) @(negedge clk);
    check("ff_pkt_ready", 32'(pkt_ready), 32'd0);
    send_pkt(8'h11, 8'h22, 8'h33);
    repeat (200) @(negedge clk);
    check("dropped_pkt", 32'(frames_done), 32'(f0 + 6));

`ifdef PS2_DEV_PARITY_CHECK_EN
    exp_q.push_back(8'hFE);
`else
    exp_q.push_back(8'hFA);
`endif
    host_send(8'hF4, 1'b1, 1'b0, ack);
    check("par_ack", 32'(ack), 32'd1);
    wait_frames(f0 + 7);
`ifdef PS2_DEV_PARITY_CHECK_EN
    check("par_stream_en", 32'(stream_en), 32'd0);
    check("par_last_cmd", 32'(last_cmd), 32'hFF);
    check("par_strobes", 32'(strobe_cnt), 32'd2);
`else
    check("par_stream_en", 32'(stream_en), 32'd1);
    check("par_last_cmd", 32'(last_cmd), 32'hF4);
    check("par_strobes", 32'(strobe_cnt), 32'd3);
`endif

    repeat (50) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
